wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Shares one Wishbone B3 slave-side bus among NUM_MASTERS bus masters using round-robin arbitration.
- Sits between the masters' intercon ports and a single slave or decoder.
- Honours LOCK, so a master can hold the bus across multiple cycles.
- Guards against hung slaves with a per-transfer watchdog that returns ERR to the owner.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
ADR_WIDTH, 32, address width
DAT_WIDTH, 32, data width
SEL_WIDTH, 4, byte-select width
TIMEOUT, 255, stalled-strobe cycles before forced ERR; 0 disables the watchdog
TO_WIDTH, 8, watchdog counter width; must satisfy TIMEOUT < 2**TO_WIDTH

Ports:
clk_i  in  1  bus clock
rst_i  in  1  reset, asynchronous, active-low
m_cyc_i  in  NUM_MASTERS  per-master CYC
m_stb_i  in  NUM_MASTERS  per-master STB
m_lock_i  in  NUM_MASTERS  per-master LOCK
m_we_i  in  NUM_MASTERS  per-master WE
m_adr_i  in  NUM_MASTERS*ADR_WIDTH  packed addresses, master 0 in LSBs
m_dat_i  in  NUM_MASTERS*DAT_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_dat_o  out  DAT_WIDTH  read data, broadcast to all masters
m_ack_o / m_err_o / m_rty_o  out  NUM_MASTERS  terminations, routed to owner only
s_cyc_o, s_stb_o, s_we_o, s_lock_o  out  1  slave-side controls
s_adr_o  out  ADR_WIDTH  slave-side address
s_dat_o  out  DAT_WIDTH  slave-side write data
s_sel_o  out  SEL_WIDTH  slave-side byte selects
s_dat_i  in  DAT_WIDTH  slave read data
s_ack_i / s_err_i / s_rty_i  in  1  slave terminations
gnt_o  out  NUM_MASTERS  one-hot current owner; 0 when idle
busy_o  out  1  high when any master owns the bus

Behaviour:
- Reset (rst_i low, asynchronous):
  - gnt_o=0, busy_o=0, FSM=IDLE, watchdog=0.
  - Round-robin pointer set to NUM_MASTERS-1, so master 0 has first priority.
  - Every s_* and m_ack/err/rty output is 0 while reset is asserted and in IDLE.
  - Assertion mid-transfer drops s_cyc_o and s_stb_o immediately.
- FSM states: IDLE, OWNED, TOERR.
- IDLE:
  - If any m_cyc_i is set, the next edge grants the first requester searching upward (with wrap) from pointer+1; go to OWNED.
  - Arbitration latency is 1 cycle from CYC to s_cyc_o.
- OWNED, owner g:
  - All s_* outputs are a combinational mux of master g.
  - s_ack/err/rty_i go to bit g only; all other bits are 0.
  - m_dat_o = s_dat_i at all times.
- Release:
  - Ownership is held while m_cyc_i[g] | m_lock_i[g].
  - On an edge where both are low, pointer := g.
  - If another requester exists, grant passes directly to the next round-robin requester (g has lowest priority); otherwise go to IDLE.
  - There is no dead cycle between back-to-back owners.
- Lock:
  - s_lock_o = m_lock_i[g].
  - A locked owner keeps the grant even with CYC low; in that case s_cyc_o=0.
- Watchdog (TIMEOUT>0):
  - Counts cycles with s_cyc_o & s_stb_o & ~(s_ack_i|s_err_i|s_rty_i).
  - Clears on any termination, on stb low, and on ownership change.
  - When count==TIMEOUT-1 and the current cycle is still unterminated, go to TOERR.
- TOERR (exactly 1 cycle):
  - m_err_o[g]=1; s_cyc_o=0 and s_stb_o=0 (slave aborted).
  - Late slave terminations are ignored.
  - Next state is OWNED with the counter cleared. The owner keeps the grant; release rules apply normally.
- Simultaneous events:
  - Termination on the same cycle as the threshold: termination wins, no TOERR.
  - A new request arriving on the release edge is included in that edge's arbitration.
- gnt_o and busy_o are registered. All data paths are combinational through the arbiter (0 added latency after grant).

Test Plan:
- Single master 1 read, slave acks on the 2nd stb cycle -> s_cyc_o high 1 cycle after m_cyc_i[1]; m_ack_o=4'b0010 for 1 cycle; m_dat_o=s_dat_i=32'hDEADBEEF; gnt_o returns to 0 after CYC drops.
- Masters 0..3 all hold CYC continuously, each dropping it after 1 acked transfer -> grant order 0,1,2,3,0; no idle cycle between owners.
- Master 2 asserts LOCK across two CYC bursts with a CYC-low gap while master 0 requests -> gnt_o stays 4'b0100 through the gap; master 0 is granted only after LOCK drops.
- TIMEOUT=4, slave never responds -> m_err_o[g] pulses on the 5th stb cycle; s_cyc_o=0 that cycle; the non-owner m_err_o bits stay 0.
- TIMEOUT=4, slave acks exactly on the 4th stalled cycle -> ack delivered, no ERR.
- rst_i pulled low mid-burst -> gnt_o=0, s_cyc_o=0 asynchronously; after release, master 0 wins a simultaneous 0/3 request.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave port among NUM_MASTERS masters,
// honours LOCK, and aborts hung transfers with a watchdog-generated ERR to the owner.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_lock_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel_i,
  output logic [DAT_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [NUM_MASTERS-1:0]           m_rty_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic                             s_lock_o,
  output logic [ADR_WIDTH-1:0]             s_adr_o,
  output logic [DAT_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]             s_sel_o,
  input  logic [DAT_WIDTH-1:0]             s_dat_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  input  logic                             s_rty_i,
  output logic [NUM_MASTERS-1:0]           gnt_o,
  output logic                             busy_o
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam bit          WDOG_EN = (TIMEOUT > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TOERR = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TO_WIDTH-1:0]    wdog_q, wdog_d;
  logic                   busy_q, busy_d;

  logic [IDX_W-1:0]       own_idx;
  logic                   own_cyc, own_stb, own_lock, own_we;
  logic [ADR_WIDTH-1:0]   own_adr;
  logic [DAT_WIDTH-1:0]   own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;
  logic                   s_term;
  logic                   stalled;

  // First requester searching upward from base+1 with wrap; base itself is checked last.
  function automatic logic [NUM_MASTERS-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                    input logic [IDX_W-1:0]       base);
    logic [NUM_MASTERS-1:0] g;
    logic                   found;
    int unsigned            idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned d = 1; d <= NUM_MASTERS; d++) begin
      idx = 32'(base) + d;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[IDX_W'(idx)]) begin
        g[IDX_W'(idx)] = 1'b1;
        found          = 1'b1;
      end
    end
    return g;
  endfunction

  // Mux the current owner's request signals out of the packed master buses.
  always_comb begin
    own_idx  = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_lock = 1'b0;
    own_we   = 1'b0;
    own_adr  = '0;
    own_dat  = '0;
    own_sel  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        own_idx  = IDX_W'(i);
        own_cyc  = m_cyc_i[i];
        own_stb  = m_stb_i[i];
        own_lock = m_lock_i[i];
        own_we   = m_we_i[i];
        own_adr  = m_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
        own_dat  = m_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
        own_sel  = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign s_term  = s_ack_i | s_err_i | s_rty_i;
  assign stalled = own_cyc & own_stb & ~s_term;

  // Next-state: arbitration, release/handover, and watchdog.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wdog_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = rr_pick(m_cyc_i, ptr_q);
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!(own_cyc || own_lock)) begin
          // Owner released: it becomes lowest priority; hand over with no dead cycle.
          ptr_d   = own_idx;
          gnt_d   = rr_pick(m_cyc_i, own_idx);
          state_d = (|m_cyc_i) ? ST_OWNED : ST_IDLE;
        end else if (WDOG_EN && stalled) begin
          if (wdog_q == TO_LAST) state_d = ST_TOERR;
          else                   wdog_d  = wdog_q + TO_WIDTH'(1);
        end
      end
      ST_TOERR: begin
        state_d = ST_OWNED;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      wdog_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      busy_q  <= busy_d;
    end
  end

  // Combinational slave-side mux and termination routing to the owner only.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    case (state_q)
      ST_OWNED: begin
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        s_we_o   = own_we;
        s_lock_o = own_lock;
        s_adr_o  = own_adr;
        s_dat_o  = own_dat;
        s_sel_o  = own_sel;
        m_ack_o  = gnt_q & {NUM_MASTERS{s_ack_i}};
        m_err_o  = gnt_q & {NUM_MASTERS{s_err_i}};
        m_rty_o  = gnt_q & {NUM_MASTERS{s_rty_i}};
      end
      ST_TOERR: begin
        // Slave is aborted; late slave terminations are dropped.
        s_we_o   = own_we;
        s_lock_o = own_lock;
        s_adr_o  = own_adr;
        s_dat_o  = own_dat;
        s_sel_o  = own_sel;
        m_err_o  = gnt_q;
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of owner/pointer/stall count.
module tb_wb_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;
  localparam int TOW = 8;

  logic              clk;
  logic              rst_i;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_lock_i, m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*SW-1:0]   m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic              s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]      gnt_o;
  logic              busy_o;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW),
    .TIMEOUT(TMO), .TO_WIDTH(TOW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_lock_i(m_lock_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          busy;
    logic          cyc, stb, lock, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat, rdat;
    logic [SW-1:0] sel;
    logic [N-1:0]  ack, err, rty;
    bit            chk_bus;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the bus, where round-robin resumes, stalled-strobe count.
  int owner, ptr, stall, stb_cnt, done_m;
  bit toerr;
  // Slave / master behaviour controls.
  int ack_at, term_kind;
  bit rand_mode, force_dat;
  int want[N];
  bit drop[N];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt_o",   64'(gnt_o),   64'(e.gnt));
      chk("busy_o",  64'(busy_o),  64'(e.busy));
      chk("s_cyc_o", 64'(s_cyc_o), 64'(e.cyc));
      chk("s_stb_o", 64'(s_stb_o), 64'(e.stb));
      chk("m_ack_o", 64'(m_ack_o), 64'(e.ack));
      chk("m_err_o", 64'(m_err_o), 64'(e.err));
      chk("m_rty_o", 64'(m_rty_o), 64'(e.rty));
      chk("m_dat_o", 64'(m_dat_o), 64'(e.rdat));
      if (e.chk_bus) begin
        chk("s_lock_o", 64'(s_lock_o), 64'(e.lock));
        chk("s_we_o",   64'(s_we_o),   64'(e.we));
        chk("s_adr_o",  64'(s_adr_o),  64'(e.adr));
        chk("s_dat_o",  64'(s_dat_o),  64'(e.wdat));
        chk("s_sel_o",  64'(s_sel_o),  64'(e.sel));
      end
    end
  end

  function automatic int pick(int base);
    for (int d = 1; d <= N; d++) begin
      int i;
      i = (base + d) % N;
      if (m_cyc_i[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; ptr = N - 1; stall = 0; stb_cnt = 0; toerr = 1'b0;
  endtask

  // One bus cycle: randomize payloads, act as slave, push expectation, advance model.
  task automatic step();
    exp_t e;
    bit   active, anyterm;
    logic sa, se, sr;
    for (int i = 0; i < N; i++) begin
      m_adr_i[i*AW +: AW] = $urandom;
      m_dat_i[i*DW +: DW] = $urandom;
      m_sel_i[i*SW +: SW] = SW'($urandom);
      m_we_i[i]           = 1'($urandom);
    end
    s_dat_i = force_dat ? 32'hDEADBEEF : $urandom;
    active  = rst_i && owner >= 0 && !toerr && m_cyc_i[owner] && m_stb_i[owner];
    sa = 1'b0; se = 1'b0; sr = 1'b0;
    if (active) begin
      if (rand_mode && stb_cnt == 0) begin
        ack_at    = $urandom_range(0, 6);
        term_kind = ($urandom % 10 < 7) ? 0 : (($urandom % 2 == 0) ? 1 : 2);
      end
      if (ack_at != 0 && stb_cnt + 1 == ack_at) begin
        if (term_kind == 0) sa = 1'b1;
        else if (term_kind == 1) se = 1'b1;
        else sr = 1'b1;
      end
    end else if (rand_mode) begin
      sa = ($urandom % 6 == 0);
      se = ($urandom % 9 == 0);
      sr = ($urandom % 9 == 0);
    end
    s_ack_i = sa; s_err_i = se; s_rty_i = sr;
    anyterm = sa | se | sr;

    e = '{default: '0};
    e.rdat    = s_dat_i;
    e.chk_bus = 1'b1;
    if (rst_i && owner >= 0) begin
      e.gnt  = N'(1) << owner;
      e.busy = 1'b1;
      if (toerr) begin
        e.err     = N'(1) << owner;
        e.chk_bus = 1'b0;
      end else begin
        e.cyc  = m_cyc_i[owner];
        e.stb  = m_stb_i[owner];
        e.lock = m_lock_i[owner];
        e.we   = m_we_i[owner];
        e.adr  = m_adr_i[owner*AW +: AW];
        e.wdat = m_dat_i[owner*DW +: DW];
        e.sel  = m_sel_i[owner*SW +: SW];
        e.ack  = sa ? N'(1) << owner : '0;
        e.err  = se ? N'(1) << owner : '0;
        e.rty  = sr ? N'(1) << owner : '0;
      end
    end
    sb.push_back(e);

    done_m = -1;
    if (!rst_i) begin
      model_reset();
    end else if (owner < 0) begin
      if (|m_cyc_i) owner = pick(ptr);
    end else if (toerr) begin
      toerr = 1'b0; stall = 0; done_m = owner;
    end else if (!(m_cyc_i[owner] || m_lock_i[owner])) begin
      ptr = owner; owner = pick(owner); stall = 0;
    end else begin
      if (active && anyterm) done_m = owner;
      if (active && !anyterm) begin
        if (stall + 1 == TMO) begin toerr = 1'b1; stall = 0; end
        else stall++;
      end else stall = 0;
    end
    stb_cnt = (rst_i && active && !anyterm) ? stb_cnt + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  // Masters with a transfer budget; each drops CYC for one cycle after a termination.
  task automatic auto_cycle();
    for (int i = 0; i < N; i++) begin
      if (drop[i]) begin
        m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0; drop[i] = 1'b0;
      end else if (want[i] > 0) begin
        m_cyc_i[i] = 1'b1;
        m_stb_i[i] = rand_mode ? ($urandom % 4 != 0) : 1'b1;
      end else begin
        m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0;
        if (rand_mode && $urandom % 6 == 0) want[i] = $urandom_range(1, 3);
      end
      if (rand_mode && $urandom % 12 == 0) m_lock_i[i] = ~m_lock_i[i];
    end
    step();
    if (done_m >= 0) begin
      if (want[done_m] > 0) want[done_m]--;
      drop[done_m] = 1'b1;
    end
  endtask

  task automatic drive(logic [N-1:0] cyc, logic [N-1:0] stb, logic [N-1:0] lock, int n);
    m_cyc_i = cyc; m_stb_i = stb; m_lock_i = lock;
    repeat (n) step();
  endtask

  initial begin
    int c;
    rst_i = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_lock_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    rand_mode = 1'b0; force_dat = 1'b0; ack_at = 1; term_kind = 0;
    for (int i = 0; i < N; i++) begin want[i] = 0; drop[i] = 1'b0; end
    model_reset();
    @(posedge clk);
    #1;
    step(); step();
    rst_i = 1'b1;
    step();

    // Single read by master 1, acked on its 2nd strobe cycle.
    force_dat = 1'b1; ack_at = 2;
    drive(4'b0010, 4'b0010, 4'b0000, 3);
    drive(4'b0000, 4'b0000, 4'b0000, 2);
    force_dat = 1'b0;

    // All masters request; one acked transfer each, master 0 comes back for a second.
    ack_at = 1;
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    c = 0;
    while (c < 100 && (want[0] + want[1] + want[2] + want[3]) > 0) begin
      auto_cycle();
      c++;
    end
    checks++;
    if (want[0] + want[1] + want[2] + want[3] != 0) begin
      errors++;
      $display("FAIL rr_drain actual=%0d expected=0 transfers left", want[0] + want[1] + want[2] + want[3]);
    end
    repeat (3) auto_cycle();

    // Master 2 holds LOCK across a CYC gap while master 0 waits.
    drive(4'b0100, 4'b0100, 4'b0100, 3);
    drive(4'b0001, 4'b0001, 4'b0100, 3);
    drive(4'b0101, 4'b0101, 4'b0100, 2);
    drive(4'b0001, 4'b0001, 4'b0000, 4);
    drive(4'b0000, 4'b0000, 4'b0000, 2);

    // Silent slave: watchdog ERR on the 5th strobe cycle.
    ack_at = 0;
    drive(4'b0010, 4'b0010, 4'b0000, 8);
    drive(4'b0000, 4'b0000, 4'b0000, 2);

    // Ack on the threshold cycle wins; one cycle later loses.
    ack_at = 4;
    drive(4'b1000, 4'b1000, 4'b0000, 6);
    ack_at = 5;
    drive(4'b1000, 4'b1000, 4'b0000, 7);
    drive(4'b0000, 4'b0000, 4'b0000, 2);

    // Asynchronous reset mid-burst, then master 0 beats master 3.
    ack_at = 0;
    drive(4'b0010, 4'b0010, 4'b0000, 3);
    rst_i = 1'b0;
    step(); step();
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    rst_i = 1'b1;
    ack_at = 1;
    repeat (3) step();
    drive(4'b0000, 4'b0000, 4'b0000, 2);

    // Random traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < N; i++) begin want[i] = 0; drop[i] = 1'b0; end
    repeat (3000) auto_cycle();
    rand_mode = 1'b0;
    ack_at = 1;
    for (int i = 0; i < N; i++) want[i] = 0;
    m_lock_i = '0;
    repeat (4) auto_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
